// File: rtl/vedic_mul_seq_8x8_if.sv
// Operand/result bundle for the sequential 8x8 vedic multiplier.
// Handshake: a transfer happens on the rising edge where valid and ready are both high; the sender holds its payload stable from raising valid until that edge.
interface vedic_mul_seq_8x8_if;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;

  modport master (output a, b, in_valid, out_ready, input in_ready, out, out_valid);
  modport slave  (input a, b, in_valid, out_ready, output in_ready, out, out_valid);
endinterface

// File: rtl/vedic_mul_seq_8x8.sv
// 8x8 unsigned multiplier that time-multiplexes one combinational 4x4 vedic core
// over four nibble passes, shift-accumulating the partial products.

module vedic_mul_2_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] out
);
  logic s1, c1, s2, c2;
  assign s1  = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign c1  = (a[1] & b[0]) & (a[0] & b[1]);
  assign s2  = (a[1] & b[1]) ^ c1;
  assign c2  = (a[1] & b[1]) & c1;
  assign out = {c2, s2, s1, a[0] & b[0]};
endmodule

module vedic_mul_4_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] out
);
  logic [3:0] q0, q1, q2, q3;

  vedic_mul_2_2 u_ll (.a(a[1:0]), .b(b[1:0]), .out(q0));
  vedic_mul_2_2 u_hl (.a(a[3:2]), .b(b[1:0]), .out(q1));
  vedic_mul_2_2 u_lh (.a(a[1:0]), .b(b[3:2]), .out(q2));
  vedic_mul_2_2 u_hh (.a(a[3:2]), .b(b[3:2]), .out(q3));

  // Vertical-and-crosswise recombination of the four 2x2 products.
  assign out = {4'd0, q0} + {2'd0, q1, 2'd0} + {2'd0, q2, 2'd0} + {q3, 4'd0};
endmodule

module vedic_mul_seq_8x8 #(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  vedic_mul_seq_8x8_if.slave        bus,
  output logic                      busy,
  output logic [1:0]                dbg_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  ra, rb;
  logic [15:0] acc, acc_sum, pp_shift, out_r;
  logic [1:0]  step;
  logic [3:0]  core_a, core_b;
  logic [7:0]  pp;
  logic        zero_hit;

  assign zero_hit = ZERO_BYPASS && ((bus.a == 8'd0) || (bus.b == 8'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = zero_hit ? DONE : CALC;
      CALC:    if (step == 2'd3) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // step[0] picks the ra nibble, step[1] the rb nibble; shift is the sum of both nibble weights.
  always_comb begin
    core_a = step[0] ? ra[7:4] : ra[3:0];
    core_b = step[1] ? rb[7:4] : rb[3:0];
    case (step)
      2'd0:    pp_shift = {8'd0, pp};
      2'd1,
      2'd2:    pp_shift = {4'd0, pp, 4'd0};
      default: pp_shift = {pp, 8'd0};
    endcase
    acc_sum = acc + pp_shift;
  end

  vedic_mul_4_4 u_core (.a(core_a), .b(core_b), .out(pp));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= 8'd0;
      rb    <= 8'd0;
      acc   <= 16'd0;
      step  <= 2'd0;
      out_r <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ra   <= bus.a;
            rb   <= bus.b;
            acc  <= 16'd0;
            step <= 2'd0;
            if (zero_hit) out_r <= 16'd0;
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (step == 2'd3) begin
            out_r <= acc_sum;
            step  <= 2'd0;
          end else begin
            step <= step + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_r;
  assign busy          = (state == CALC) || (state == DONE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_vedic_mul_seq_8x8.sv
// Bench for vedic_mul_seq_8x8: directed scenarios on a bypass and a non-bypass instance,
// then a randomized stream checked against an expected queue.
module tb_vedic_mul_seq_8x8;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  vedic_mul_seq_8x8_if ifz ();
  vedic_mul_seq_8x8_if ifn ();

  logic        busy_z, busy_n;
  logic [1:0]  st_z, st_n;
  logic [7:0]  a, b;
  logic        in_valid, out_ready;
  logic        use_nb;

  assign ifz.a         = a;
  assign ifz.b         = b;
  assign ifz.in_valid  = in_valid & ~use_nb;
  assign ifz.out_ready = out_ready;
  assign ifn.a         = a;
  assign ifn.b         = b;
  assign ifn.in_valid  = in_valid & use_nb;
  assign ifn.out_ready = out_ready;

  logic        o_in_ready, o_out_valid, o_busy;
  logic [15:0] o_out;
  logic [1:0]  o_state;
  assign o_in_ready  = use_nb ? ifn.in_ready  : ifz.in_ready;
  assign o_out_valid = use_nb ? ifn.out_valid : ifz.out_valid;
  assign o_out       = use_nb ? ifn.out       : ifz.out;
  assign o_busy      = use_nb ? busy_n        : busy_z;
  assign o_state     = use_nb ? st_n          : st_z;

  vedic_mul_seq_8x8 #(.ZERO_BYPASS(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(ifz), .busy(busy_z), .dbg_state(st_z));
  vedic_mul_seq_8x8 #(.ZERO_BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(ifn), .busy(busy_n), .dbg_state(st_n));

  // Present operands at a negedge and hold them until the edge that accepts them.
  task automatic accept_op(input logic [7:0] av, input logic [7:0] bv, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (o_in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // n = rising edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int n, output bit stayed_busy);
    n = -1;
    stayed_busy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_in_ready || !o_busy) stayed_busy = 1'b0;
      if (o_out_valid) begin
        n = k;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0; use_nb = 1'b0;
    #12;
    tests_run++; if (o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %0b want 1", o_in_ready); end
    tests_run++; if (o_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", o_out_valid); end
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    tests_run++; if (o_out !== 16'd0) begin tests_failed++; $display("FAIL reset_out got %0d want 0", o_out); end
    tests_run++; if (o_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", o_state); end
    tests_run++; if (ifn.in_ready !== 1'b1 || ifn.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_nb got rdy=%0b vld=%0b want 1/0", ifn.in_ready, ifn.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_max_operands();
    bit ok, sb; int n;
    out_ready = 1'b1;
    accept_op(8'd255, 8'd255, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL t1_accept got %0b want 1", ok); end
    wait_valid(n, sb);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL t1_latency got %0d want 4", n); end
    tests_run++; if (o_out !== 16'hFE01) begin tests_failed++; $display("FAIL t1_out got %0d want 65025", o_out); end
    @(posedge clk); @(negedge clk);
    tests_run++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL t1_release got vld=%0b rdy=%0b want 0/1", o_out_valid, o_in_ready); end
  endtask

  task automatic test_busy_window();
    bit ok, sb; int n;
    out_ready = 1'b1;
    accept_op(8'h12, 8'h34, ok);
    wait_valid(n, sb);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL t2_latency got %0d want 4", n); end
    tests_run++; if (o_out !== 16'd936) begin tests_failed++; $display("FAIL t2_out got %0d want 936", o_out); end
    tests_run++; if (sb !== 1'b1) begin tests_failed++; $display("FAIL t2_busy_window got %0b want 1", sb); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_zero_bypass();
    bit ok, sb; int n;
    out_ready = 1'b1;
    use_nb = 1'b0;
    accept_op(8'd0, 8'd200, ok);
    wait_valid(n, sb);
    tests_run++; if (n != 0) begin tests_failed++; $display("FAIL t3_bypass_latency got %0d want 0", n); end
    tests_run++; if (o_out !== 16'd0) begin tests_failed++; $display("FAIL t3_bypass_out got %0d want 0", o_out); end
    @(posedge clk); @(negedge clk);
    accept_op(8'd77, 8'd0, ok);
    wait_valid(n, sb);
    tests_run++; if (n != 0 || o_out !== 16'd0) begin tests_failed++; $display("FAIL t3_bypass_b0 got lat=%0d out=%0d want 0/0", n, o_out); end
    @(posedge clk); @(negedge clk);
    use_nb = 1'b1;
    accept_op(8'd7, 8'd9, ok);
    wait_valid(n, sb);
    tests_run++; if (n != 4 || o_out !== 16'd63) begin tests_failed++; $display("FAIL t3_nb_7x9 got lat=%0d out=%0d want 4/63", n, o_out); end
    @(posedge clk); @(negedge clk);
    accept_op(8'd0, 8'd200, ok);
    wait_valid(n, sb);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL t3_nb_latency got %0d want 4", n); end
    tests_run++; if (o_out !== 16'd0) begin tests_failed++; $display("FAIL t3_nb_out got %0d want 0", o_out); end
    @(posedge clk); @(negedge clk);
    use_nb = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok, sb, held; int n;
    out_ready = 1'b0;
    accept_op(8'd13, 8'd11, ok);
    wait_valid(n, sb);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL t4_latency got %0d want 4", n); end
    held = 1'b1;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (o_out_valid !== 1'b1 || o_out !== 16'd143 || o_busy !== 1'b1 || o_in_ready !== 1'b0) held = 1'b0;
    end
    tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL t4_hold got %0b want 1 (out=%0d)", held, o_out); end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    tests_run++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL t4_release got vld=%0b rdy=%0b busy=%0b want 0/1/0", o_out_valid, o_in_ready, o_busy); end
  endtask

  task automatic test_reset_mid_op();
    bit ok, sb, quiet; int n;
    out_ready = 1'b1;
    accept_op(8'd200, 8'd100, ok);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++; if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0) begin tests_failed++; $display("FAIL t5_abort got rdy=%0b busy=%0b vld=%0b want 1/0/0", o_in_ready, o_busy, o_out_valid); end
    tests_run++; if (o_out !== 16'd0 || o_state !== 2'd0) begin tests_failed++; $display("FAIL t5_abort_regs got out=%0d st=%0d want 0/0", o_out, o_state); end
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (o_out_valid !== 1'b0) quiet = 1'b0;
    end
    tests_run++; if (quiet !== 1'b1) begin tests_failed++; $display("FAIL t5_no_result got %0b want 1", quiet); end
    accept_op(8'd3, 8'd5, ok);
    wait_valid(n, sb);
    tests_run++; if (n != 4 || o_out !== 16'd15) begin tests_failed++; $display("FAIL t5_after got lat=%0d out=%0d want 4/15", n, o_out); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random_stream();
    logic [15:0] exp_q[$];
    int n_ops = 1000;
    int got = 0;
    use_nb = 1'b0;
    fork
      begin : src
        for (int i = 0; i < n_ops; i++) begin
          logic [7:0]  av, bv;
          logic [15:0] prod;
          bit acc_ok;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          av = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
          bv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
          prod = 16'(av) * 16'(bv);
          @(negedge clk);
          a = av; b = bv; in_valid = 1'b1;
          acc_ok = 1'b0;
          for (int k = 0; k < 200; k++) begin
            if (o_in_ready) begin acc_ok = 1'b1; break; end
            @(negedge clk);
          end
          if (!acc_ok) begin
            tests_run++; tests_failed++;
            $display("FAIL t6_accept_timeout got op %0d stuck want accept", i);
            in_valid = 1'b0;
            break;
          end
          exp_q.push_back(prod);
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
      end
      begin : snk
        for (int cyc = 0; cyc < 40000 && got < n_ops; cyc++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (o_out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
              tests_failed++;
              $display("FAIL t6_unexpected got out=%0d want no result", o_out);
            end else begin
              logic [15:0] e;
              e = exp_q.pop_front();
              if (o_out !== e) begin tests_failed++; $display("FAIL t6_product got %0d want %0d (result %0d)", o_out, e, got); end
            end
            got++;
          end
        end
      end
    join
    tests_run++; if (got != n_ops) begin tests_failed++; $display("FAIL t6_count got %0d want %0d", got, n_ops); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL t6_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_max_operands();
    test_busy_window();
    test_zero_bypass();
    test_backpressure();
    test_reset_mid_op();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
